uart_wb_master: RTL



---
 rtl/uart_wb_master_pkg.sv | 22 ++
 rtl/uart_phy.sv | 113 +++++++++++
 rtl/uart_wb_master.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_wb_master_pkg.sv
// rtl/uart_wb_master_pkg.sv - shared state encodings and protocol constants for the UART bridge
package uart_wb_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RX_DATA   = 3'd1,
    S_BUS_REQ   = 3'd2,
    S_BUS_WAIT  = 3'd3,
    S_TX_STATUS = 3'd4,
    S_TX_DATA   = 3'd5
  } state_t;

  localparam logic [7:0] ACK_BYTE    = 8'h06;
  localparam logic [7:0] NAK_BYTE    = 8'h15;
  localparam int         FRAME_BYTES = 4;

  // Bits 6:4 are reserved and must be zero for a command to be honoured.
  function automatic logic cmd_valid(input logic [7:0] cmd);
    return cmd[6:4] == 3'b000;
  endfunction

endpackage

// File: rtl/uart_phy.sv
// rtl/uart_phy.sv - 8N1 UART receiver and transmitter, bit period set by DIV clock cycles
module uart_phy #(
  parameter int DIV = 416
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_rx_tdata,
  output logic       o_rx_tvalid,
  output logic       o_rx_ferr,
  output logic       o_rx_active,
  input  logic [7:0] i_tx_tdata,
  input  logic       i_tx_tvalid,
  output logic       o_tx_tready,
  output logic       o_tx
);

  localparam int              CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2 - 1);

  logic             r_rx_meta, r_rx_sync, r_rx_busy, r_rx_valid, r_rx_ferr;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [3:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;

  logic             r_tx_busy, r_tx;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [3:0]       r_tx_bit;
  logic [8:0]       r_tx_shift;
  logic             w_tx_last;

  assign o_rx_tdata  = r_rx_shift;
  assign o_rx_tvalid = r_rx_valid;
  assign o_rx_ferr   = r_rx_ferr;
  assign o_rx_active = r_rx_busy;

  // rx bit index: 0 = start, 1..8 = data, 9 = stop; sampled when r_rx_cnt hits 0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 4'd0;
      r_rx_shift <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_meta  <= i_rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      if (!r_rx_busy) begin
        if (!r_rx_sync) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= HALF;
          r_rx_bit  <= 4'd0;
        end
      end else if (r_rx_cnt != '0) begin
        r_rx_cnt <= r_rx_cnt - 1'b1;
      end else begin
        r_rx_cnt <= FULL;
        if (r_rx_bit == 4'd0) begin
          if (r_rx_sync) r_rx_busy <= 1'b0;
          else           r_rx_bit  <= 4'd1;
        end else if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          r_rx_bit  <= 4'd0;
          if (r_rx_sync) r_rx_valid <= 1'b1;
          else           r_rx_ferr  <= 1'b1;
        end else begin
          r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 4'd1;
        end
      end
    end
  end

  // Accepting on the final stop-bit cycle keeps back-to-back bytes at exactly one stop bit.
  assign w_tx_last   = r_tx_busy && (r_tx_bit == 4'd9) && (r_tx_cnt == '0);
  assign o_tx_tready = !r_tx_busy || w_tx_last;
  assign o_tx        = r_tx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_busy  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 4'd0;
      r_tx_shift <= 9'h1FF;
      r_tx       <= 1'b1;
    end else if (i_tx_tvalid && o_tx_tready) begin
      r_tx_busy  <= 1'b1;
      r_tx_cnt   <= FULL;
      r_tx_bit   <= 4'd0;
      r_tx_shift <= {1'b1, i_tx_tdata};
      r_tx       <= 1'b0;
    end else if (r_tx_busy) begin
      if (r_tx_cnt != '0) begin
        r_tx_cnt <= r_tx_cnt - 1'b1;
      end else if (r_tx_bit == 4'd9) begin
        r_tx_busy <= 1'b0;
        r_tx_bit  <= 4'd0;
      end else begin
        r_tx       <= r_tx_shift[0];
        r_tx_shift <= {1'b1, r_tx_shift[8:1]};
        r_tx_bit   <= r_tx_bit + 4'd1;
        r_tx_cnt   <= FULL;
      end
    end
  end

endmodule

// File: rtl/uart_wb_master.sv
// rtl/uart_wb_master.sv - UART command frames to single Wishbone B4 pipelined transfers
module uart_wb_master
  import uart_wb_master_pkg::*;
#(
  parameter int CLK_HZ         = 48000000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic        i_uart_rx,
  output logic        o_uart_tx
);

  localparam int         DIV        = CLK_HZ / BAUD;
  localparam int         GAP_CYCLES = 16 * DIV;
  localparam int         GAP_W      = $clog2(GAP_CYCLES + 1);
  localparam int         TO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] LAST_BYTE  = 2'(FRAME_BYTES - 1);

  state_t            r_state, w_next;
  logic              r_we, r_ack_ok;
  logic [3:0]        r_addr;
  logic [31:0]       r_wdata, r_rdata;
  logic [1:0]        r_byte_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;

  logic [7:0] w_rx_data, w_tx_data;
  logic       w_rx_valid, w_rx_ferr, w_rx_active;
  logic       w_tx_valid, w_tx_ready;
  logic       w_timeout, w_gap_expired, w_ack_hit;
  logic       w_cyc, w_stb;

  uart_phy #(.DIV(DIV)) u_phy (
    .i_clk       (i_wb_clk),
    .i_rst       (i_wb_rst),
    .i_rx        (i_uart_rx),
    .o_rx_tdata  (w_rx_data),
    .o_rx_tvalid (w_rx_valid),
    .o_rx_ferr   (w_rx_ferr),
    .o_rx_active (w_rx_active),
    .i_tx_tdata  (w_tx_data),
    .i_tx_tvalid (w_tx_valid),
    .o_tx_tready (w_tx_ready),
    .o_tx        (o_uart_tx)
  );

  // An ack only counts once stb has been accepted (or already was, in BUS_WAIT).
  assign w_ack_hit     = i_wb_ack && (((r_state == S_BUS_REQ) && !i_wb_stall) ||
                                      (r_state == S_BUS_WAIT));
  assign w_timeout     = (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
  assign w_gap_expired = (r_gap_cnt == GAP_W'(GAP_CYCLES));

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (w_rx_valid && cmd_valid(w_rx_data))
          w_next = w_rx_data[7] ? S_RX_DATA : S_BUS_REQ;
      S_RX_DATA:
        if (w_rx_ferr || w_gap_expired)                    w_next = S_IDLE;
        else if (w_rx_valid && (r_byte_cnt == LAST_BYTE))  w_next = S_BUS_REQ;
      S_BUS_REQ:
        if (w_ack_hit || w_timeout) w_next = S_TX_STATUS;
        else if (!i_wb_stall)       w_next = S_BUS_WAIT;
      S_BUS_WAIT:
        if (w_ack_hit || w_timeout) w_next = S_TX_STATUS;
      S_TX_STATUS:
        if (w_tx_ready) w_next = (r_ack_ok && !r_we) ? S_TX_DATA : S_IDLE;
      S_TX_DATA:
        if (w_tx_ready && (r_byte_cnt == LAST_BYTE)) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cyc      = 1'b0;
    w_stb      = 1'b0;
    w_tx_valid = 1'b0;
    w_tx_data  = ACK_BYTE;
    case (r_state)
      S_BUS_REQ: begin
        w_cyc = 1'b1;
        w_stb = 1'b1;
      end
      S_BUS_WAIT:
        w_cyc = 1'b1;
      S_TX_STATUS: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_ack_ok ? ACK_BYTE : NAK_BYTE;
      end
      S_TX_DATA: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_rdata[31:24];
      end
      default: ;
    endcase
  end

  assign o_wb_cyc  = w_cyc;
  assign o_wb_stb  = w_stb;
  assign o_wb_we   = r_we;
  assign o_wb_addr = r_addr;
  assign o_wb_data = r_wdata;

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_we       <= 1'b0;
      r_addr     <= 4'h0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_ack_ok   <= 1'b0;
      r_byte_cnt <= 2'd0;
      r_to_cnt   <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_to_cnt <= '0;
      case (r_state)
        S_IDLE: begin
          r_byte_cnt <= 2'd0;
          r_gap_cnt  <= '0;
          if (w_rx_valid && cmd_valid(w_rx_data)) begin
            r_we   <= w_rx_data[7];
            r_addr <= w_rx_data[3:0];
          end
        end
        S_RX_DATA:
          if (w_rx_valid) begin
            r_wdata    <= {r_wdata[23:0], w_rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_gap_cnt  <= '0;
          end else if (!w_rx_active) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        S_BUS_REQ, S_BUS_WAIT: begin
          r_to_cnt   <= r_to_cnt + 1'b1;
          r_ack_ok   <= w_ack_hit;
          r_byte_cnt <= 2'd0;
          if (w_ack_hit) r_rdata <= i_wb_data;
        end
        S_TX_DATA:
          if (w_tx_ready) begin
            r_rdata    <= {r_rdata[23:0], 8'h00};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        default: ;
      endcase
    end
  end

endmodule
